vmem_scanout: RTL

- Video raster scan-out engine sitting directly in front of the byte-wide video memory (15-bit address, 8-bit registered read data, 1-cycle read latency).
- Generates VGA-style timing and a scaled memory address stream, consumes the returned pixel byte, and emits an aligned RGB332 pixel with hsync/vsync/de.
- clk is the pixel-domain clock; pix_ce qualifies pixel advances.

---
 rtl/vmem_pkg.sv | 51 +++++
 rtl/vmem_timing_gen.sv | 73 +++++++
 rtl/vmem_scanout.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vmem_pkg.sv
// Shared constants for the video scan-out engine: 640x480@60 timing defaults,
// counter sizing, RGB332 field positions and the per-axis phase decode.
package vmem_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_PIX_SHIFT = 2;
    localparam int unsigned DEF_ADDR_W    = 15;

    // Wide enough for any total up to 4095 on either axis.
    localparam int unsigned CNT_W = 12;

    localparam int unsigned RGB_R_MSB = 7;
    localparam int unsigned RGB_R_LSB = 5;
    localparam int unsigned RGB_G_MSB = 4;
    localparam int unsigned RGB_G_LSB = 2;
    localparam int unsigned RGB_B_MSB = 1;
    localparam int unsigned RGB_B_LSB = 0;
    localparam logic [7:0]  RGB_BLACK = 8'h00;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    // Phases are contiguous: ACT, FP, SYNC, then BP up to the wrap.
    function automatic phase_e phase_of(input logic [CNT_W-1:0] cnt,
                                        input int unsigned act,
                                        input int unsigned fp,
                                        input int unsigned sy);
        phase_e ph;
        if (cnt < CNT_W'(act))
            ph = PH_ACT;
        else if (cnt < CNT_W'(act + fp))
            ph = PH_FP;
        else if (cnt < CNT_W'(act + fp + sy))
            ph = PH_SYNC;
        else
            ph = PH_BP;
        return ph;
    endfunction

endpackage

// File: rtl/vmem_timing_gen.sv
// Raster counters and phase decode for the scan-out engine: hcnt/vcnt advance
// on pix_ce, en low clears them synchronously.
module vmem_timing_gen
    import vmem_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             v_act,
    output logic             de_raw,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             h_wrap,
    output logic             v_wrap
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    phase_e           h_phase, v_phase;

    always_comb begin
        h_wrap = pix_ce && (hcnt_q == CNT_W'(H_TOTAL - 1));
        v_wrap = h_wrap && (vcnt_q == CNT_W'(V_TOTAL - 1));
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!en) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (pix_ce) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
            if (h_wrap)
                vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    always_comb begin
        h_phase   = phase_of(hcnt_q, H_ACTIVE, H_FP, H_SYNC);
        v_phase   = phase_of(vcnt_q, V_ACTIVE, V_FP, V_SYNC);
        v_act     = (v_phase == PH_ACT);
        de_raw    = (h_phase == PH_ACT) && v_act;
        hsync_raw = (h_phase != PH_SYNC);
        vsync_raw = (v_phase != PH_SYNC);
    end

    assign hcnt = hcnt_q;
    assign vcnt = vcnt_q;

endmodule

// File: rtl/vmem_scanout.sv
// Video memory scan-out: raster timing, scaled address generation and a
// two-stage pix_ce pipeline producing aligned RGB332 with syncs and de.
// Optional border overlay when VMEM_SCANOUT_BORDER_EN is defined.
module vmem_scanout
    import vmem_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned PIX_SHIFT = DEF_PIX_SHIFT,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              pix_ce,
    output logic [ADDR_W-1:0] vmem_addr,
    input  logic [7:0]        vmem_data,
`ifdef VMEM_SCANOUT_BORDER_EN
    input  logic [7:0]        border_color,
`endif
    output logic [7:0]        rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> PIX_SHIFT);
    localparam logic [CNT_W-1:0]  SUB_MASK = CNT_W'((1 << PIX_SHIFT) - 1);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             v_act, de_raw, hsync_raw, vsync_raw, h_wrap, v_wrap;
    logic             first_raw;

    vmem_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .pix_ce    (pix_ce),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .v_act     (v_act),
        .de_raw    (de_raw),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .h_wrap    (h_wrap),
        .v_wrap    (v_wrap)
    );

    logic [ADDR_W-1:0] row_base_q, row_base_d;

    always_comb begin
        row_base_d = row_base_q;
        if (!en || v_wrap)
            row_base_d = '0;
        else if (h_wrap && v_act && ((vcnt & SUB_MASK) == SUB_MASK))
            row_base_d = row_base_q + ROW_STEP;
    end

    assign vmem_addr = de_raw ? row_base_q + ADDR_W'(hcnt >> PIX_SHIFT) : row_base_q;
    assign first_raw = de_raw && (hcnt == '0) && (vcnt == '0);

`ifdef VMEM_SCANOUT_BORDER_EN
    logic border_raw;
    logic border_d1_q, border_d1_d;
    assign border_raw = de_raw && ((hcnt == '0) || (hcnt == CNT_W'(H_ACTIVE - 1)) ||
                                   (vcnt == '0) || (vcnt == CNT_W'(V_ACTIVE - 1)));
`endif

    // Stage 1: controls delayed while memory answers the current address
    logic       de_d1_q, de_d1_d;
    logic       hs_d1_q, hs_d1_d;
    logic       vs_d1_q, vs_d1_d;
    logic       first_d1_q, first_d1_d;
    logic       ce_d1_q, ce_d1_d;
    logic [7:0] data_hold_q, data_hold_d;
    // Stage 2: registered outputs
    logic [7:0] rgb_q, rgb_d;
    logic       de_q, de_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] mem_byte;
    logic [7:0] pix_byte;

    // Memory answers one clk after the advance; if pix_ce is sparse the next
    // advance sees the following address's data, so capture it right away.
    assign mem_byte = ce_d1_q ? vmem_data : data_hold_q;

`ifdef VMEM_SCANOUT_BORDER_EN
    assign pix_byte = border_d1_q ? border_color : mem_byte;
`else
    assign pix_byte = mem_byte;
`endif

    always_comb begin
        de_d1_d       = de_d1_q;
        hs_d1_d       = hs_d1_q;
        vs_d1_d       = vs_d1_q;
        first_d1_d    = first_d1_q;
        ce_d1_d       = pix_ce;
        data_hold_d   = ce_d1_q ? vmem_data : data_hold_q;
        rgb_d         = rgb_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;
`ifdef VMEM_SCANOUT_BORDER_EN
        border_d1_d   = border_d1_q;
`endif
        if (!en) begin
            de_d1_d     = 1'b0;
            hs_d1_d     = 1'b1;
            vs_d1_d     = 1'b1;
            first_d1_d  = 1'b0;
            ce_d1_d     = 1'b0;
            data_hold_d = '0;
            rgb_d       = RGB_BLACK;
            de_d        = 1'b0;
            hsync_d     = 1'b1;
            vsync_d     = 1'b1;
`ifdef VMEM_SCANOUT_BORDER_EN
            border_d1_d = 1'b0;
`endif
        end else if (pix_ce) begin
            de_d1_d       = de_raw;
            hs_d1_d       = hsync_raw;
            vs_d1_d       = vsync_raw;
            first_d1_d    = first_raw;
            rgb_d         = de_d1_q ? pix_byte : RGB_BLACK;
            de_d          = de_d1_q;
            hsync_d       = hs_d1_q;
            vsync_d       = vs_d1_q;
            frame_start_d = first_d1_q;
`ifdef VMEM_SCANOUT_BORDER_EN
            border_d1_d   = border_raw;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base_q    <= '0;
            de_d1_q       <= 1'b0;
            hs_d1_q       <= 1'b1;
            vs_d1_q       <= 1'b1;
            first_d1_q    <= 1'b0;
            ce_d1_q       <= 1'b0;
            data_hold_q   <= '0;
            rgb_q         <= RGB_BLACK;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
`ifdef VMEM_SCANOUT_BORDER_EN
            border_d1_q   <= 1'b0;
`endif
        end else begin
            row_base_q    <= row_base_d;
            de_d1_q       <= de_d1_d;
            hs_d1_q       <= hs_d1_d;
            vs_d1_q       <= vs_d1_d;
            first_d1_q    <= first_d1_d;
            ce_d1_q       <= ce_d1_d;
            data_hold_q   <= data_hold_d;
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
`ifdef VMEM_SCANOUT_BORDER_EN
            border_d1_q   <= border_d1_d;
`endif
        end
    end

    assign rgb         = rgb_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule
